// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Sums a frame of up to TERMS unsigned products (closed early by `last`) into
//   an ACC_W-bit total and presents the finished total on a valid/ready port.
//   Intended as the MAC tail behind the 2x2 gate-level multiplier.
//
// Ports
//   clk        in   1       rising-edge clock for all state
//   reset      in   1       synchronous, active-high
//   in_valid   in   1       product/last valid this cycle
//   in_ready   out  1       block can accept a product this cycle
//   product    in   PROD_W  unsigned product (zero-extended to ACC_W)
//   last       in   1       closes the frame after this term
//   out_valid  out  1       sum/count/overflow valid, held until taken
//   out_ready  in   1       downstream takes the result this cycle
//   sum        out  ACC_W   frame total modulo 2^ACC_W
//   count      out  CNT_W   products in the frame (1..TERMS)
//   overflow   out  1       a carry out of ACC_W occurred within the frame
// -----------------------------------------------------------------------------
module product_accumulator #(
   parameter int unsigned PROD_W = 4,
   parameter int unsigned ACC_W  = 8,
   parameter int unsigned TERMS  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PROD_W-1:0]            product,
   input  logic                         last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_W-1:0]             sum,
   output logic [$clog2(TERMS+1)-1:0]   count,
   output logic                         overflow
);

   localparam int unsigned CNT_W = $clog2(TERMS + 1);

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]       state_q,     state_d;
   logic [ACC_W-1:0] acc_q,       acc_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             ovf_q,       ovf_d;
   logic [ACC_W-1:0] sum_q,       sum_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic             overflow_q,  overflow_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;

   logic             accept_c;
   logic             take_c;
   logic             close_c;
   logic [ACC_W:0]   add_c;
   logic [CNT_W-1:0] cnt_inc_c;

   // Handshake decode; in_ready_q tracks state so there is no comb path from inputs.
   assign accept_c  = in_valid & in_ready_q;
   assign take_c    = out_valid_q & out_ready;
   assign close_c   = last | (cnt_q == CNT_W'(TERMS - 1));
   // Top bit of the widened add is the carry out of the accumulator.
   assign add_c     = {1'b0, acc_q} + (ACC_W + 1)'(product);
   assign cnt_inc_c = cnt_q + CNT_W'(1);

   // Next-state and output-register logic.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      sum_d       = sum_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;

      case (state_q)
         ST_ACCUM: begin
            if (accept_c) begin
               acc_d = add_c[ACC_W-1:0];
               ovf_d = ovf_q | add_c[ACC_W];
               cnt_d = cnt_inc_c;
               if (close_c) begin
                  // Publish the total including this term on the same edge.
                  sum_d       = add_c[ACC_W-1:0];
                  count_d     = cnt_inc_c;
                  overflow_d  = ovf_q | add_c[ACC_W];
                  out_valid_d = 1'b1;
                  in_ready_d  = 1'b0;
                  state_d     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            // New frame starts clean; in_ready returns the cycle after the take.
            if (take_c) begin
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_ACCUM;
            end
         end
         default: begin
            state_d     = ST_ACCUM;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State registers; reset aborts any frame and discards a held result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         sum_q       <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//   Directed bench for product_accumulator. Two instances share all inputs:
//   dut8 (ACC_W=8) and dut5 (ACC_W=5, to exercise wrap/overflow).
// -----------------------------------------------------------------------------
module tb_product_accumulator;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [3:0] product;
   logic       last;
   logic       out_ready;

   logic       in_ready;
   logic       out_valid;
   logic [7:0] sum;
   logic [2:0] count;
   logic       overflow;

   logic       in_ready5;
   logic       out_valid5;
   logic [4:0] sum5;
   logic [2:0] count5;
   logic       overflow5;

   int total;
   int bad;

   product_accumulator #(.PROD_W(4), .ACC_W(8), .TERMS(4)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .product(product), .last(last), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .count(count), .overflow(overflow)
   );

   product_accumulator #(.PROD_W(4), .ACC_W(5), .TERMS(4)) dut5 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready5),
      .product(product), .last(last), .out_valid(out_valid5), .out_ready(out_ready),
      .sum(sum5), .count(count5), .overflow(overflow5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one product and wait (bounded) until it is accepted.
   task automatic send(input logic [3:0] p, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      product  = p;
      last     = l;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      last     = 1'b0;
   endtask

   task automatic take;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (sum !== 8'd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", sum); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_full_frame;
      send(4'd9, 1'b0);
      send(4'd6, 1'b0);
      send(4'd3, 1'b0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b exp=0", out_valid); end
      send(4'd9, 1'b0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_out_valid got=%b exp=1", out_valid); end
      total++; if (sum !== 8'd27) begin bad++; $display("FAIL full_sum got=%0d exp=27", sum); end
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_overflow got=%b exp=0", overflow); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      take();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_take_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_take_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_last;
      // out_ready high during ACCUM must be ignored.
      out_ready = 1'b1;
      send(4'd2, 1'b0);
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL last_accum_valid got=%b exp=0", out_valid); end
      send(4'd3, 1'b1);
      total++; if (sum !== 8'd5) begin bad++; $display("FAIL last_sum got=%0d exp=5", sum); end
      total++; if (count !== 3'd2) begin bad++; $display("FAIL last_count got=%0d exp=2", count); end
      take();
      send(4'd1, 1'b1);
      total++; if (sum !== 8'd1) begin bad++; $display("FAIL last_single_sum got=%0d exp=1", sum); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL last_single_count got=%0d exp=1", count); end
      take();
   endtask

   task automatic test_backpressure;
      send(4'd4, 1'b0);
      send(4'd4, 1'b1);
      in_valid  = 1'b1;
      product   = 4'd7;
      last      = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (sum !== 8'd8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable cyc=%0d sum=%0d valid=%b ready=%b exp sum=8 valid=1 ready=0",
                     i, sum, out_valid, in_ready);
         end
      end
      take();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL hold_after_take ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
      end
      tick();
      in_valid = 1'b0;
      last     = 1'b0;
      total++; if (out_valid !== 1'b1 || sum !== 8'd7 || count !== 3'd1) begin
         bad++; $display("FAIL hold_queued valid=%b sum=%0d count=%0d exp valid=1 sum=7 count=1", out_valid, sum, count);
      end
      take();
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 4; i++) send(4'd9, 1'b0);
      total++; if (sum5 !== 5'd4) begin bad++; $display("FAIL wrap_sum5 got=%0d exp=4", sum5); end
      total++; if (overflow5 !== 1'b1) begin bad++; $display("FAIL wrap_ovf5 got=%b exp=1", overflow5); end
      total++; if (sum !== 8'd36 || overflow !== 1'b0) begin
         bad++; $display("FAIL wrap_sum8 sum=%0d ovf=%b exp sum=36 ovf=0", sum, overflow);
      end
      take();
      send(4'd1, 1'b1);
      total++; if (sum5 !== 5'd1 || overflow5 !== 1'b0 || count5 !== 3'd1) begin
         bad++; $display("FAIL wrap_next sum5=%0d ovf5=%b count5=%0d exp 1 0 1", sum5, overflow5, count5);
      end
      take();
   endtask

   task automatic test_reset_abort;
      send(4'd5, 1'b0);
      send(4'd5, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL abort_mid valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
      end
      send(4'd4, 1'b0);
      send(4'd4, 1'b1);
      total++; if (sum !== 8'd8 || count !== 3'd2) begin
         bad++; $display("FAIL abort_mid_frame sum=%0d count=%0d exp sum=8 count=2", sum, count);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'd0) begin
         bad++; $display("FAIL abort_hold valid=%b ready=%b sum=%0d exp 0 1 0", out_valid, in_ready, sum);
      end
      send(4'd4, 1'b0);
      send(4'd4, 1'b1);
      total++; if (sum !== 8'd8 || count !== 3'd2) begin
         bad++; $display("FAIL abort_hold_frame sum=%0d count=%0d exp sum=8 count=2", sum, count);
      end
      take();
   endtask

   // Random handshakes, products from a 2x2 multiplier model, scoreboarded.
   task automatic test_random;
      int q_tot[$];
      int q_cnt[$];
      int acc, cnt, frames, checked, cycles, cur_p, et, ec;
      bit have_item, cur_l;
      acc = 0; cnt = 0; frames = 0; checked = 0; cycles = 0;
      have_item = 1'b0; cur_p = 0; cur_l = 1'b0;
      while (checked < 200 && cycles < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid === 1'b1 && out_ready) begin
            if (q_tot.size() == 0) begin
               total++; bad++;
               $display("FAIL rand_unexpected sum=%0d count=%0d", sum, count);
            end else begin
               et = q_tot.pop_front();
               ec = q_cnt.pop_front();
               total++;
               if (sum !== 8'(et % 256) || count !== 3'(ec) || overflow !== (et >= 256) ||
                   sum5 !== 5'(et % 32) || overflow5 !== (et >= 32) || out_valid5 !== 1'b1) begin
                  bad++;
                  $display("FAIL rand_frame%0d sum=%0d cnt=%0d ovf=%b sum5=%0d ovf5=%b exp tot=%0d cnt=%0d",
                           checked, sum, count, overflow, sum5, overflow5, et, ec);
               end
            end
            checked++;
         end
         if (!have_item && frames < 200) begin
            cur_p     = $urandom_range(0, 3) * $urandom_range(0, 3);
            cur_l     = ($urandom_range(0, 3) == 0);
            have_item = 1'b1;
         end
         in_valid = have_item && ($urandom_range(0, 2) != 0);
         product  = 4'(cur_p);
         last     = cur_l;
         if (in_valid && in_ready === 1'b1) begin
            acc += cur_p;
            cnt++;
            have_item = 1'b0;
            if (cur_l || cnt == 4) begin
               q_tot.push_back(acc);
               q_cnt.push_back(cnt);
               acc = 0;
               cnt = 0;
               frames++;
            end
         end
         tick();
         cycles++;
      end
      in_valid  = 1'b0;
      last      = 1'b0;
      out_ready = 1'b0;
      total++; if (checked != 200) begin
         bad++; $display("FAIL rand_frames got=%0d exp=200", checked);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      product   = 4'd0;
      last      = 1'b0;
      out_ready = 1'b0;
      total     = 0;
      bad       = 0;
      test_reset();
      test_full_frame();
      test_last();
      test_backpressure();
      test_wrap();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
